// File: rtl/traffic_intersection_controller.sv
// Multi-approach traffic intersection controller.
// Runs a round-robin GREEN -> YELLOW -> ALL-RED rotation timed in tick strobes,
// with emergency preemption and a flashing-amber maintenance mode.
module traffic_intersection_controller #(
    parameter int unsigned NUM_DIR      = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned GREEN_TICKS  = 30,
    parameter int unsigned YELLOW_TICKS = 4,
    parameter int unsigned ALLRED_TICKS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       flash_en,
    input  logic                       preempt_req,
    input  logic [$clog2(NUM_DIR)-1:0] preempt_dir,
    output logic [NUM_DIR-1:0]         red,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         green,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic [2:0]                 state_o
);

    localparam int unsigned DIR_W = $clog2(NUM_DIR);

    // Zero durations behave as one tick; store the terminal count of each phase.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(((GREEN_TICKS  == 0) ? 1 : GREEN_TICKS)  - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(((YELLOW_TICKS == 0) ? 1 : YELLOW_TICKS) - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(((ALLRED_TICKS == 0) ? 1 : ALLRED_TICKS) - 1);

    localparam logic [DIR_W:0]   NUM_DIR_EXT = (DIR_W + 1)'(NUM_DIR);
    localparam logic [DIR_W-1:0] LAST_DIR    = DIR_W'(NUM_DIR - 1);

    typedef enum logic [2:0] {
        ST_ALLRED  = 3'd0,
        ST_GREEN   = 3'd1,
        ST_YELLOW  = 3'd2,
        ST_PREEMPT = 3'd3,
        ST_FLASH   = 3'd4
    } state_e;

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [DIR_W-1:0]   dir_q,    dir_d;
    logic               blink_q,  blink_d;
    logic [NUM_DIR-1:0] red_q,    red_d;
    logic [NUM_DIR-1:0] yellow_q, yellow_d;
    logic [NUM_DIR-1:0] green_q,  green_d;

    logic [CNT_W-1:0]   last_c;
    logic               expire_c;
    logic               preempt_valid_c;
    logic [DIR_W-1:0]   dir_next_c;
    logic [NUM_DIR-1:0] onehot_c;

    // State, counter, direction, blink and lamp registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_ALLRED;
            cnt_q    <= '0;
            dir_q    <= LAST_DIR;
            blink_q  <= 1'b0;
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            blink_q  <= blink_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
        end
    end

    // Next-state, phase timer and lamp decode (lamps follow the next state).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        blink_d  = blink_q;
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;

        unique case (state_q)
            ST_GREEN:  last_c = GREEN_LAST;
            ST_YELLOW: last_c = YELLOW_LAST;
            default:   last_c = ALLRED_LAST;
        endcase

        expire_c        = tick && (cnt_q == last_c);
        preempt_valid_c = preempt_req && ({1'b0, preempt_dir} < NUM_DIR_EXT);
        dir_next_c      = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);

        if (flash_en) begin
            if (state_q != ST_FLASH) begin
                state_d = ST_FLASH;
                cnt_d   = '0;
                blink_d = 1'b0;
            end else if (tick) begin
                blink_d = ~blink_q;
            end
        end else begin
            unique case (state_q)
                ST_FLASH: begin
                    state_d = ST_ALLRED;
                    cnt_d   = '0;
                    blink_d = 1'b0;
                end
                ST_ALLRED: begin
                    if (expire_c) begin
                        cnt_d = '0;
                        if (preempt_valid_c) begin
                            dir_d   = preempt_dir;
                            state_d = ST_PREEMPT;
                        end else begin
                            dir_d   = dir_next_c;
                            state_d = ST_GREEN;
                        end
                    end else if (tick) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_GREEN: begin
                    if (preempt_valid_c) begin
                        cnt_d   = '0;
                        state_d = (preempt_dir == dir_q) ? ST_PREEMPT : ST_YELLOW;
                    end else if (expire_c) begin
                        cnt_d   = '0;
                        state_d = ST_YELLOW;
                    end else if (tick) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_YELLOW: begin
                    if (expire_c) begin
                        cnt_d   = '0;
                        state_d = ST_ALLRED;
                    end else if (tick) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_PREEMPT: begin
                    // Direction is frozen here; only the request level matters.
                    if (!preempt_req) begin
                        cnt_d   = '0;
                        state_d = ST_YELLOW;
                    end
                end
                default: begin
                    state_d = ST_ALLRED;
                    cnt_d   = '0;
                end
            endcase
        end

        onehot_c = NUM_DIR'(1) << dir_d;
        unique case (state_d)
            ST_GREEN, ST_PREEMPT: begin
                green_d = onehot_c;
                red_d   = ~onehot_c;
            end
            ST_YELLOW: begin
                yellow_d = onehot_c;
                red_d    = ~onehot_c;
            end
            ST_FLASH: begin
                yellow_d = {NUM_DIR{blink_d}};
                red_d    = '0;
            end
            default: ;
        endcase
    end

    assign red        = red_q;
    assign yellow     = yellow_q;
    assign green      = green_q;
    assign active_dir = dir_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_traffic_intersection_controller.sv
// Directed self-checking bench for traffic_intersection_controller.
module tb_traffic_intersection_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       flash_en;
    logic       preempt_req;
    logic [1:0] preempt_dir;
    logic [3:0] red, yellow, green;
    logic [1:0] active_dir;
    logic [2:0] state_o;

    // Five-approach instance: 3-bit preempt_dir can carry out-of-range codes.
    logic       preempt_req5;
    logic [2:0] preempt_dir5;
    logic [4:0] red5, yellow5, green5;
    logic [2:0] active_dir5;
    logic [2:0] state5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    traffic_intersection_controller #(
        .NUM_DIR(4), .CNT_W(16), .GREEN_TICKS(3), .YELLOW_TICKS(2), .ALLRED_TICKS(1)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .flash_en(flash_en),
        .preempt_req(preempt_req), .preempt_dir(preempt_dir),
        .red(red), .yellow(yellow), .green(green),
        .active_dir(active_dir), .state_o(state_o)
    );

    traffic_intersection_controller #(
        .NUM_DIR(5), .CNT_W(16), .GREEN_TICKS(3), .YELLOW_TICKS(2), .ALLRED_TICKS(1)
    ) dut5 (
        .clk(clk), .reset(reset), .tick(tick), .flash_en(flash_en),
        .preempt_req(preempt_req5), .preempt_dir(preempt_dir5),
        .red(red5), .yellow(yellow5), .green(green5),
        .active_dir(active_dir5), .state_o(state5)
    );

    // {state, dir, red, yellow, green}
    function automatic logic [16:0] pk(input int st, input int d, input logic [3:0] r,
                                       input logic [3:0] y, input logic [3:0] g);
        pk = {3'(st), 2'(d), r, y, g};
    endfunction

    function automatic logic [16:0] obs();
        obs = {state_o, active_dir, red, yellow, green};
    endfunction

    // Expected lamps after n ticks from reset release: G3 Y2 R1 per approach.
    function automatic logic [16:0] exp_rot(input int n);
        int t, d, p;
        logic [3:0] g;
        if (n == 0) return pk(0, 3, 4'hF, 4'h0, 4'h0);
        t = (n - 1) % 24;
        d = t / 6;
        p = t % 6;
        g = 4'(1 << d);
        if (p < 3)      exp_rot = pk(1, d, ~g, 4'h0, g);
        else if (p < 5) exp_rot = pk(2, d, ~g, g, 4'h0);
        else            exp_rot = pk(0, d, 4'hF, 4'h0, 4'h0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        tick         = 1'b1;
        flash_en     = 1'b0;
        preempt_req  = 1'b0;
        preempt_dir  = 2'd0;
        preempt_req5 = 1'b0;
        preempt_dir5 = 3'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b1; flash_en = 1'b0; preempt_req = 1'b0; preempt_dir = 2'd0;
        preempt_req5 = 1'b0; preempt_dir5 = 3'd0;
        step();
        n_checks++;
        if (obs() !== pk(0, 3, 4'hF, 4'h0, 4'h0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs(), pk(0, 3, 4'hF, 4'h0, 4'h0));
        end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) step();
            n_checks++;
            if (obs() !== exp_rot(k)) begin
                n_fail++;
                $display("FAIL rotation cycle %0d: got %h expected %h", k, obs(), exp_rot(k));
            end
        end
    endtask

    task automatic test_slow_tick();
        int n;
        logic tk;
        do_reset();
        n = 0;
        for (int c = 0; c < 100; c++) begin
            tk   = ((c % 4) == 3);
            tick = tk;
            step();
            if (tk) n++;
            n_checks++;
            if (obs() !== exp_rot(n)) begin
                n_fail++;
                $display("FAIL slow_tick cycle %0d: got %h expected %h", c, obs(), exp_rot(n));
            end
        end
        tick = 1'b1;
    endtask

    task automatic test_preempt_other();
        logic [16:0] exp_q[$];
        do_reset();
        step(); step();                       // second green[0] cycle
        preempt_req = 1'b1; preempt_dir = 2'd2;
        exp_q.push_back(pk(2, 0, 4'hE, 4'h1, 4'h0));
        exp_q.push_back(pk(2, 0, 4'hE, 4'h1, 4'h0));
        exp_q.push_back(pk(0, 0, 4'hF, 4'h0, 4'h0));
        for (int i = 0; i < 20; i++) exp_q.push_back(pk(3, 2, 4'hB, 4'h0, 4'h4));
        foreach (exp_q[i]) begin
            step();
            n_checks++;
            if (obs() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL preempt_other step %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
        end
        preempt_req = 1'b0;
        exp_q.delete();
        exp_q.push_back(pk(2, 2, 4'hB, 4'h4, 4'h0));
        exp_q.push_back(pk(2, 2, 4'hB, 4'h4, 4'h0));
        exp_q.push_back(pk(0, 2, 4'hF, 4'h0, 4'h0));
        exp_q.push_back(pk(1, 3, 4'h7, 4'h0, 4'h8));
        foreach (exp_q[i]) begin
            step();
            n_checks++;
            if (obs() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL preempt_release step %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
        end
    endtask

    task automatic test_preempt_same();
        do_reset();
        for (int i = 0; i < 7; i++) step();   // first green[1] cycle
        n_checks++;
        if (obs() !== pk(1, 1, 4'hD, 4'h0, 4'h2)) begin
            n_fail++;
            $display("FAIL preempt_same_setup: got %h expected %h", obs(), pk(1, 1, 4'hD, 4'h0, 4'h2));
        end
        preempt_req = 1'b1; preempt_dir = 2'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 2) preempt_dir = 2'd3;   // ignored while preempted
            n_checks++;
            if (obs() !== pk(3, 1, 4'hD, 4'h0, 4'h2)) begin
                n_fail++;
                $display("FAIL preempt_same hold %0d: got %h expected %h", i, obs(), pk(3, 1, 4'hD, 4'h0, 4'h2));
            end
        end
        preempt_req = 1'b0;
        step();
        n_checks++;
        if (obs() !== pk(2, 1, 4'hD, 4'h2, 4'h0)) begin
            n_fail++;
            $display("FAIL preempt_same_release: got %h expected %h", obs(), pk(2, 1, 4'hD, 4'h2, 4'h0));
        end
    endtask

    task automatic test_flash();
        logic [16:0] exp_q[$];
        do_reset();
        for (int i = 0; i < 4; i++) step();   // first yellow[0] cycle
        flash_en = 1'b1;
        exp_q.push_back(pk(4, 0, 4'h0, 4'h0, 4'h0));
        exp_q.push_back(pk(4, 0, 4'h0, 4'hF, 4'h0));
        exp_q.push_back(pk(4, 0, 4'h0, 4'h0, 4'h0));
        exp_q.push_back(pk(4, 0, 4'h0, 4'hF, 4'h0));
        foreach (exp_q[i]) begin
            step();
            n_checks++;
            if (obs() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL flash step %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
        end
        flash_en = 1'b0;
        exp_q.delete();
        exp_q.push_back(pk(0, 0, 4'hF, 4'h0, 4'h0));
        exp_q.push_back(pk(1, 1, 4'hD, 4'h0, 4'h2));
        foreach (exp_q[i]) begin
            step();
            n_checks++;
            if (obs() !== exp_q[i]) begin
                n_fail++;
                $display("FAIL flash_exit step %0d: got %h expected %h", i, obs(), exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 14; i++) step();  // mid green[2]
        n_checks++;
        if (obs() !== pk(1, 2, 4'hB, 4'h0, 4'h4)) begin
            n_fail++;
            $display("FAIL async_reset_setup: got %h expected %h", obs(), pk(1, 2, 4'hB, 4'h0, 4'h4));
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (obs() !== pk(0, 3, 4'hF, 4'h0, 4'h0)) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %h expected %h", obs(), pk(0, 3, 4'hF, 4'h0, 4'h0));
        end
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (obs() !== pk(1, 0, 4'hE, 4'h0, 4'h1)) begin
            n_fail++;
            $display("FAIL async_reset_first_green: got %h expected %h", obs(), pk(1, 0, 4'hE, 4'h0, 4'h1));
        end
    endtask

    task automatic test_invalid_dir();
        do_reset();
        preempt_req5 = 1'b1; preempt_dir5 = 3'd6;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({state5, active_dir5, green5, red5} !== {3'd1, 3'd0, 5'h01, 5'h1E}) begin
                n_fail++;
                $display("FAIL invalid_dir step %0d: got %h expected %h", i,
                         {state5, active_dir5, green5, red5}, {3'd1, 3'd0, 5'h01, 5'h1E});
            end
        end
        step();
        n_checks++;
        if ({state5, yellow5} !== {3'd2, 5'h01}) begin
            n_fail++;
            $display("FAIL invalid_dir_yellow: got %h expected %h", {state5, yellow5}, {3'd2, 5'h01});
        end
        preempt_req5 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_slow_tick();
        test_preempt_other();
        test_preempt_same();
        test_flash();
        test_async_reset();
        test_invalid_dir();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
